alu_muldiv: RTL and testbench

//  Iterative multiply/divide unit alongside the combinational ALU in the CPU core.
//  - Executes MLT (unsigned WIDTH x WIDTH -> 2*WIDTH) and DIV (unsigned 2*WIDTH / WIDTH
//    -> WIDTH quotient, WIDTH remainder).
//  - Uses the ALU's Z/C/V/S flag convention, with a start/busy/done handshake to the

---
 rtl/alu_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/alu_muldiv.sv | 131 +++++++++++++
 tb/tb_alu_muldiv.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag indices and the mul/div unit's enums.
package alu_pkg;

    // Combinational ALU opcodes
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SHL  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_PASS = 4'd7
    } AluOp;

    // Flag bit positions, common to the ALU and the mul/div unit
    localparam int unsigned ALU_FLAG_Z = 0;
    localparam int unsigned ALU_FLAG_C = 1;
    localparam int unsigned ALU_FLAG_V = 2;
    localparam int unsigned ALU_FLAG_S = 3;

    typedef enum logic [1:0] {
        MDOP_MUL = 2'd0,
        MDOP_DIV = 2'd1
    } MdOp;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } MdState;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath.
// MUL: acc = {carry, hi, multiplier}; add multiplicand to hi when acc[0] is set, shift right.
// DIV: acc = {partial remainder (WIDTH+1), dividend low / quotient}; shift left, trial
//      subtract the divisor, keep the difference when there is no borrow.
module muldiv_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [2*WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  MdOp                op,
    output logic [2*WIDTH:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Single add/shift or subtract/shift step selected by op
    always_comb begin
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;
        borrow  = 1'b0;
        acc_out = acc_in;
        if (op == MDOP_DIV) begin
            rem_sh  = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
            diff    = {1'b0, rem_sh} - {2'b00, operand};
            borrow  = diff[WIDTH+1];
            acc_out = {(borrow ? rem_sh : diff[WIDTH:0]), acc_in[WIDTH-2:0], ~borrow};
        end else begin
            sum     = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, operand} : '0);
            acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply/divide unit with start/busy/done handshake and ALU-style flags.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 div_zero
);

    // Wide enough to hold WIDTH itself so a 16-bit build never wraps early
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [3:0] FLAGS_V = 4'(1 << ALU_FLAG_V);

    MdState               state;
    MdOp                  op_q;
    logic [2*WIDTH:0]     acc;
    logic [2*WIDTH:0]     acc_next;
    logic [WIDTH-1:0]     operand;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   fin_result;
    logic [3:0]           fin_flags;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in  (acc),
        .operand (operand),
        .op      (op_q),
        .acc_out (acc_next)
    );

    assign fin_result = acc_next[2*WIDTH-1:0];

    // Completion flags from the value the last step produces
    always_comb begin
        fin_flags = '0;
        if (op_q == MDOP_DIV) begin
            fin_flags[ALU_FLAG_Z] = (fin_result[WIDTH-1:0] == '0);
            fin_flags[ALU_FLAG_S] = fin_result[WIDTH-1];
        end else begin
            fin_flags[ALU_FLAG_Z] = (fin_result == '0);
            fin_flags[ALU_FLAG_S] = fin_result[2*WIDTH-1];
        end
    end

    // Control FSM, operand capture, iteration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MD_IDLE;
            op_q     <= MDOP_MUL;
            acc      <= '0;
            operand  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            flags    <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (op)
                            MDOP_MUL: begin
                                op_q    <= MDOP_MUL;
                                operand <= a[WIDTH-1:0];
                                acc     <= {{(WIDTH+1){1'b0}}, b};
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= MD_RUN;
                            end
                            MDOP_DIV: begin
                                if (b == '0) begin
                                    done     <= 1'b1;
                                    div_zero <= 1'b1;
                                    result   <= a;
                                    flags    <= '0;
                                end else if (a[2*WIDTH-1:WIDTH] >= b) begin
                                    // Quotient would not fit in WIDTH bits
                                    done     <= 1'b1;
                                    div_zero <= 1'b0;
                                    result   <= a;
                                    flags    <= FLAGS_V;
                                end else begin
                                    op_q    <= MDOP_DIV;
                                    operand <= b;
                                    acc     <= {1'b0, a};
                                    cnt     <= '0;
                                    busy    <= 1'b1;
                                    state   <= MD_RUN;
                                end
                            end
                            default: begin
                                // Reserved op: complete at once, keep previous result
                                done     <= 1'b1;
                                div_zero <= 1'b0;
                                flags    <= '0;
                            end
                        endcase
                    end
                end
                MD_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= MD_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= fin_result;
                        flags    <= fin_flags;
                        div_zero <= 1'b0;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: 8-bit and 16-bit instances.
module tb_alu_muldiv;

    typedef struct packed {
        int          id;
        logic [31:0] res;
        logic [3:0]  fl;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [15:0] a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dz8;
    logic [15:0] result8;
    logic [3:0]  flags8;

    logic        start16 = 1'b0;
    logic [1:0]  op16 = 2'd0;
    logic [31:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy16, done16, dz16;
    logic [31:0] result16;
    logic [3:0]  flags16;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   vid = 0;
    logic seen_busy;

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .flags(flags8), .div_zero(dz8)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .flags(flags16), .div_zero(dz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation on every done pulse
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check($sformatf("v%0d_result", e8.id), {16'b0, result8}, e8.res);
                check($sformatf("v%0d_flags", e8.id), {28'b0, flags8}, {28'b0, e8.fl});
                check($sformatf("v%0d_divzero", e8.id), {31'b0, dz8}, {31'b0, e8.dz});
                check($sformatf("v%0d_cycle", e8.id), cyc, e8.cyc);
            end
        end
        if (done16) begin
            if (q16.size() == 0) begin
                check("unexpected_done16", 32'd1, 32'd0);
            end else begin
                e16 = q16.pop_front();
                check($sformatf("w%0d_result", e16.id), result16, e16.res);
                check($sformatf("w%0d_flags", e16.id), {28'b0, flags16}, {28'b0, e16.fl});
                check($sformatf("w%0d_cycle", e16.id), cyc, e16.cyc);
            end
        end
    end

    // Issue one 8-bit op and scramble the inputs afterwards
    task automatic issue8(input logic [1:0] o, input logic [15:0] aa, input logic [7:0] bb,
                          input logic [15:0] er, input logic [3:0] ef, input logic ed,
                          input int lat);
        exp_t e;
        op8 = o; a8 = aa; b8 = bb; start8 = 1'b1;
        e.id = vid; e.res = {16'b0, er}; e.fl = ef; e.dz = ed; e.cyc = cyc + lat;
        q8.push_back(e);
        vid++;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 16'($urandom);
        b8 = 8'($urandom);
        op8 = 2'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            check("done_timeout", 32'(q8.size() + q16.size()), 32'd0);
            q8.delete();
            q16.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int c0;
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy8}, 32'd0);
        check("reset_done", {31'b0, done8}, 32'd0);
        check("reset_result", {16'b0, result8}, 32'd0);
        check("reset_flags", {28'b0, flags8}, 32'd0);
        check("reset_divzero", {31'b0, dz8}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Normal MUL / DIV, latency WIDTH+1
        issue8(2'd0, 16'h0012, 8'h34, 16'h03A8, 4'b0000, 1'b0, 9);
        drain(40);
        issue8(2'd0, 16'hAAFF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9);
        drain(40);
        issue8(2'd0, 16'h1200, 8'h7F, 16'h0000, 4'b0001, 1'b0, 9);
        drain(40);
        issue8(2'd1, 16'h1234, 8'h56, 16'h1036, 4'b0000, 1'b0, 9);
        drain(40);
        // Reserved op keeps the previous result
        issue8(2'd2, 16'hBEEF, 8'h11, 16'h1036, 4'b0000, 1'b0, 1);
        drain(40);
        issue8(2'd1, 16'h00FF, 8'h01, 16'h00FF, 4'b1000, 1'b0, 9);
        drain(40);
        issue8(2'd1, 16'h0005, 8'h07, 16'h0500, 4'b0001, 1'b0, 9);
        drain(40);

        // Divide by zero: one-cycle fast path, busy never high
        seen_busy = 1'b0;
        fork
            issue8(2'd1, 16'h0100, 8'h00, 16'h0100, 4'b0000, 1'b1, 1);
            repeat (3) @(negedge clk) if (busy8) seen_busy = 1'b1;
        join
        check("divzero_busy", {31'b0, seen_busy}, 32'd0);
        drain(40);
        // div_zero cleared by the next normal completion
        issue8(2'd0, 16'h0002, 8'h03, 16'h0006, 4'b0000, 1'b0, 9);
        drain(40);
        // Quotient overflow, including the hi == b boundary
        issue8(2'd1, 16'h0500, 8'h04, 16'h0500, 4'b0100, 1'b0, 1);
        drain(40);
        issue8(2'd1, 16'h0400, 8'h04, 16'h0400, 4'b0100, 1'b0, 1);
        drain(40);

        // Start while busy is ignored
        issue8(2'd0, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 1'b0, 9);
        repeat (2) @(posedge clk);
        #1;
        check("busy_midrun", {31'b0, busy8}, 32'd1);
        op8 = 2'd1; a8 = 16'h0100; b8 = 8'h00; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        drain(40);

        // Reset mid-run: abort, no done, outputs back to reset values
        c0 = cyc;
        op8 = 2'd0; a8 = 16'h0007; b8 = 8'h09; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (cyc < c0 + 4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'b0, busy8}, 32'd0);
        check("abort_result", {16'b0, result8}, 32'd0);
        check("abort_flags", {28'b0, flags8}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        issue8(2'd0, 16'h0003, 8'h05, 16'h000F, 4'b0000, 1'b0, 9);
        drain(40);

        // Reset and start together: start lost
        reset = 1'b1; op8 = 2'd0; a8 = 16'h0003; b8 = 8'h03; start8 = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("reset_start_result", {16'b0, result8}, 32'd0);

        // Back-to-back: second start in the first done cycle
        issue8(2'd0, 16'h0010, 8'h10, 16'h0100, 4'b0000, 1'b0, 9);
        n = 0;
        while (!done8 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_done", {31'b0, done8}, 32'd1);
        issue8(2'd1, 16'h0064, 8'h0A, 16'h000A, 4'b0000, 1'b0, 9);
        drain(40);

        // 16-bit instance: counter must run all 16 iterations
        op16 = 2'd0; a16 = 32'h0000FFFF; b16 = 16'h0002; start16 = 1'b1;
        e.id = 0; e.res = 32'h0001FFFE; e.fl = 4'b0000; e.dz = 1'b0; e.cyc = cyc + 17;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0; a16 = '0; b16 = '0;
        drain(60);
        op16 = 2'd1; a16 = 32'h0001_0000; b16 = 16'h0003; start16 = 1'b1;
        e.id = 1; e.res = 32'h0001_5555; e.fl = 4'b0000; e.dz = 1'b0; e.cyc = cyc + 17;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

endmodule
